// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the memory slave: transfer/size encodings,
// slave FSM states, response codes and the byte-lane helper.
// Optional error checking is controlled by the AHB_MEM_ERR_EN macro (see top).
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Little-endian byte-lane enables for a transfer of 2^size bytes at addr_lo.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            2'd0:    mask = 4'b0001 << addr_lo;
            2'd1:    mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_mem_bank.sv
// Word-organised memory with per-byte write enables and a combinational read
// port. Contents are never reset.
module ahb_mem_bank #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // Byte-lane write: only enabled lanes of the addressed word change.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave with a fixed number of wait states per transfer.
// Define AHB_MEM_ERR_EN to reject misaligned, oversized and out-of-range
// transfers with a two-cycle ERROR response; without it those transfers are
// folded into legal ones (aligned down, word size, address wrapped).
module ahb_lite_mem_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    slv_state_e        state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              write_q;

    logic              accept;
    logic              take;
    logic              is_legal;
    logic              complete;
    logic [1:0]        size_eff;
    logic [ADDR_W-1:0] addr_eff;
    logic [31:0]       bank_rdata;

    assign accept = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    // A new address phase is only taken while this slave is itself ready.
    assign take   = accept && hreadyout;

    // Decode the address phase into a legal, aligned access (or flag it illegal).
    always_comb begin
        size_eff = (hsize == HSIZE_BYTE) ? 2'd0 : (hsize == HSIZE_HALF) ? 2'd1 : 2'd2;
        addr_eff = haddr[ADDR_W-1:0];
`ifdef AHB_MEM_ERR_EN
        is_legal = (hsize <= HSIZE_WORD)
                && !(hsize == HSIZE_HALF && haddr[0])
                && !(hsize == HSIZE_WORD && haddr[1:0] != 2'd0)
                && (haddr[31:ADDR_W] == '0);
`else
        is_legal = 1'b1;
        if (size_eff == 2'd1)      addr_eff[0]   = 1'b0;
        else if (size_eff == 2'd2) addr_eff[1:0] = 2'd0;
`endif
    end

`ifndef AHB_MEM_ERR_EN
    // Upper address bits are deliberately ignored: the memory wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^haddr[31:ADDR_W];
`endif

    // Slave FSM and wait counter; the counter reloads on every accept and
    // saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else if (take) begin
            state_q <= is_legal ? ST_WAIT : ST_ERR1;
            cnt_q   <= WS;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q != 4'd0) cnt_q   <= cnt_q - 4'd1;
                    else               state_q <= ST_IDLE;
                end
`ifdef AHB_MEM_ERR_EN
                ST_ERR1: state_q <= ST_ERR2;
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Capture the address-phase attributes for the following data phase.
    always_ff @(posedge clk) begin
        if (take) begin
            addr_q  <= addr_eff;
            size_q  <= size_eff;
            write_q <= hwrite;
        end
    end

    assign complete = (state_q == ST_WAIT) && (cnt_q == 4'd0);

`ifdef AHB_MEM_ERR_EN
    assign hreadyout = complete || (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign hresp     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
    assign hreadyout = complete || (state_q == ST_IDLE);
    assign hresp     = HRESP_OKAY;
`endif

    // Read data is only presented in a read completion cycle.
    assign hrdata = (complete && !write_q) ? bank_rdata : 32'h0;

    ahb_mem_bank #(
        .AW (ADDR_W - 2)
    ) u_bank (
        .clk   (clk),
        .we    (complete && write_q && !rst),
        .be    (lane_mask(size_q, addr_q[1:0])),
        .addr  (addr_q[ADDR_W-1:2]),
        .wdata (hwdata),
        .rdata (bank_rdata)
    );

endmodule

// File: doc/ahb_lite_mem_slave.md
AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter ADDR_W, default 12, SHALL set the byte-address width decoded from haddr.
REQ-003 Parameter WAIT_STATES, default 2, SHALL set the number of hreadyout=0 cycles inserted in every OKAY data phase; the range is 0..15.
REQ-004 Port clk, input, 1 bit, SHALL be the rising-edge clock for all logic.
REQ-005 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-006 Port hsel, input, 1 bit, SHALL be the slave select.
REQ-007 Port haddr, input, 32 bits, SHALL be the address-phase byte address; only bits [ADDR_W-1:0] are decoded.
REQ-008 Port htrans, input, 2 bits, SHALL carry IDLE=0, BUSY=1, NONSEQ=2 or SEQ=3.
REQ-009 Port hsize, input, 3 bits, SHALL carry byte=0, half=1 or word=2; values of 3 and above are illegal.
REQ-010 Port hwrite, input, 1 bit, SHALL select write (1) or read (0).
REQ-011 Port hready, input, 1 bit, SHALL be the bus-level ready returned from the interconnect.
REQ-012 Port hwdata, input, 32 bits, SHALL be the data-phase write data.
REQ-013 Port hrdata, output, 32 bits, SHALL be the read data.
REQ-014 Port hreadyout, output, 1 bit, SHALL be the slave ready.
REQ-015 Port hresp, output, 1 bit, SHALL be the response: OKAY=0, ERROR=1.

Function
REQ-016 Memory SHALL be 2^(ADDR_W-2) words of 32 bits, little-endian byte lanes, with no reset of contents.
REQ-017 An address phase SHALL be accepted when hsel=1, hready=1 and htrans[1]=1, capturing haddr, hsize and hwrite; NONSEQ and SEQ are treated identically and hburst is not decoded.
REQ-018 IDLE or BUSY transfers, and cycles with hsel=0, SHALL get a zero-wait OKAY response and SHALL NOT change the FSM state.
REQ-019 FSM states SHALL be IDLE, WAIT, ERR1 and ERR2.
REQ-020 From IDLE, an accept SHALL transition to WAIT, or to ERR1 if the transfer is illegal.
REQ-021 WAIT SHALL hold hreadyout=0 for WAIT_STATES cycles and then drive hreadyout=1 with hresp=0 for exactly one completion cycle.
REQ-022 With WAIT_STATES=0, the completion cycle SHALL be the first data-phase cycle.
REQ-023 A new accept in the completion cycle SHALL start the next data phase back-to-back; otherwise the FSM SHALL return to IDLE.
REQ-024 A write SHALL update only the lanes selected by hsize and haddr[1:0], using hwdata from the completion cycle, at the clock edge that ends the completion cycle.
REQ-025 A read SHALL drive hrdata = mem[addr_q] for the full word (all lanes) in the completion cycle; hrdata SHALL be 0 in all other cycles.
REQ-026 A read immediately following a write to the same address SHALL return the newly written data.
REQ-027 ERR1 SHALL drive hreadyout=0, hresp=1; ERR2 SHALL then drive hreadyout=1, hresp=1.
REQ-028 An error transfer SHALL insert no wait states and SHALL NOT write memory.
REQ-029 An accept in ERR2 SHALL be handled as in REQ-023.
REQ-030 The wait counter SHALL be 4 bits, reload on each accept, and never wrap.

Reset
REQ-031 When rst=1 at a clock edge, the state SHALL become IDLE, hreadyout 1, hresp 0, hrdata 0 and the counter 0, aborting any transfer in progress with no memory write.
REQ-032 Reset SHALL take effect on the next edge, with no asynchronous path.

Configuration
REQ-033 With AHB_MEM_ERR_EN defined, misaligned transfers (half with haddr[0]=1, word with haddr[1:0]≠0), illegal hsize, and haddr[31:ADDR_W]≠0 SHALL trigger ERR1.
REQ-034 With AHB_MEM_ERR_EN undefined, the ERR states SHALL be removed, hresp SHALL be tied to 0, upper address bits SHALL be ignored (wrap modulo depth), misaligned low address bits SHALL be forced to alignment, and hsize≥3 SHALL be treated as word.

Structure
REQ-035 Package ahb_pkg SHALL hold the htrans and hsize enums, the slave-state enum, and the OKAY and ERROR constants.
REQ-036 Sub-module ahb_mem_bank SHALL hold the byte-lane-write, combinational-read memory array.

Verification
REQ-037 Reset, then an IDLE htrans SHALL give hreadyout=1, hresp=0, hrdata=0.
REQ-038 With WAIT_STATES=2, a word write of 0xDEADBEEF to 0x10 SHALL give hreadyout 0,0,1; a following read of 0x10 SHALL return 0xDEADBEEF after 2 waits.
REQ-039 A byte write of 0x55 to 0x13 over 0xDEADBEEF, then a read of 0x10, SHALL return 0x55ADBEEF.
REQ-040 Back-to-back NONSEQ writes to 0x0 and 0x4 with WAIT_STATES=0 SHALL give hreadyout constantly 1, and both words SHALL be stored.
REQ-041 With AHB_MEM_ERR_EN defined, a word read at 0x2 SHALL give (hreadyout,hresp)=(0,1),(1,1) with no memory change; with it undefined, the same read SHALL return mem[0x0] with OKAY.
REQ-042 Asserting rst in the second wait cycle of a write to 0x20 SHALL give hreadyout=1 next cycle and leave mem[0x20] unchanged.
